// File: rtl/iddr_gearbox.sv
// iddr_gearbox: input DDR deserialiser. WIDTH lanes are captured on both SCLK edges
// and regrouped into RATIO-bit words per lane, with runtime bitslip word alignment.
module iddr_gearbox #(
  parameter int WIDTH = 1,
  parameter int RATIO = 4
) (
  input  logic                     SCLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         D,
  input  logic                     ALIGNWD,
  output logic [WIDTH*RATIO-1:0]   Q,
  output logic                     VALID,
  output logic [$clog2(RATIO)-1:0] SLIP
);

  localparam int HW   = 2 * RATIO;
  localparam int HALF = RATIO / 2;
  localparam int SW   = $clog2(RATIO);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  if ((RATIO != 2) && (RATIO != 4) && (RATIO != 8)) begin : g_ratio_check
    $fatal(1, "iddr_gearbox: RATIO must be 2, 4 or 8");
  end

  logic [WIDTH-1:0]         rise_q;
  logic [WIDTH-1:0]         fall_q;
  logic [WIDTH-1:0][HW-1:0] hist_q, hist_d;
  logic [WIDTH-1:0][HW-1:0] shift_s;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [SW-1:0]            slip_q, slip_d;
  logic [SW-1:0]            lock_q, lock_d;
  logic [WIDTH*RATIO-1:0]   q_q, q_d, word_s;
  logic                     valid_q, valid_d;
  logic                     wrap_s, accept_s;

  // Falling-edge capture; reset is honoured on this edge too so the first pair is (0,0)
  always_ff @(negedge SCLK) begin
    if (RST) begin
      fall_q <= {WIDTH{1'b0}};
    end else begin
      fall_q <= D;
    end
  end

  // History update and word extraction; the word sees the pair pushed at this same edge
  always_comb begin
    hist_d  = hist_q;
    shift_s = {(WIDTH*HW){1'b0}};
    word_s  = {(WIDTH*RATIO){1'b0}};
    for (int n = 0; n < WIDTH; n++) begin
      hist_d[n]  = {hist_q[n][HW-3:0], rise_q[n], fall_q[n]};
      shift_s[n] = hist_d[n] >> slip_q;
      for (int i = 0; i < RATIO; i++) begin
        word_s[n*RATIO + i] = shift_s[n][RATIO-1-i];
      end
    end
  end

  // Word counter, output load and bitslip with lockout
  always_comb begin
    wrap_s   = (cnt_q == CW'(HALF - 1));
    accept_s = ALIGNWD && (lock_q == {SW{1'b0}});
    cnt_d    = wrap_s ? {CW{1'b0}} : cnt_q + CW'(1);
    valid_d  = wrap_s;
    q_d      = wrap_s ? word_s : q_q;
    if (accept_s) begin
      // slip_q is read by this edge's word, so the new offset lands on the next word
      slip_d = slip_q + SW'(1);
      lock_d = SW'(HALF - 1);
    end else if (lock_q != {SW{1'b0}}) begin
      slip_d = slip_q;
      lock_d = lock_q - SW'(1);
    end else begin
      slip_d = slip_q;
      lock_d = lock_q;
    end
  end

  // Rising-edge state: capture, history, counter, slip and registered outputs
  always_ff @(posedge SCLK) begin
    if (RST) begin
      rise_q  <= {WIDTH{1'b0}};
      hist_q  <= {(WIDTH*HW){1'b0}};
      cnt_q   <= {CW{1'b0}};
      slip_q  <= {SW{1'b0}};
      lock_q  <= {SW{1'b0}};
      q_q     <= {(WIDTH*RATIO){1'b0}};
      valid_q <= 1'b0;
    end else begin
      rise_q  <= D;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      slip_q  <= slip_d;
      lock_q  <= lock_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign Q     = q_q;
  assign VALID = valid_q;
  assign SLIP  = slip_q;

endmodule

// File: tb/tb_iddr_gearbox.sv
// Directed bench for iddr_gearbox: three instances (RATIO 2/4/8) share one stimulus
// sequence; expected words are queued at drive time and popped on each VALID.
module tb_iddr_gearbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw;
  logic [2:0]  d;

  logic [1:0]  q2;
  logic        v2;
  logic [0:0]  s2;
  logic [11:0] q4;
  logic        v4;
  logic [1:0]  s4;
  logic [7:0]  q8;
  logic        v8;
  logic [2:0]  s8;

  int checks   = 0;
  int failures = 0;

  logic en2 = 1'b0;
  logic en4 = 1'b0;
  logic en8 = 1'b0;
  logic [1:0]  exp2_q [$];
  logic [11:0] exp4_q [$];
  logic [7:0]  exp8_q [$];
  logic [1:0]  e2;
  logic [11:0] e4;
  logic [7:0]  e8;

  always #5 clk = ~clk;

  iddr_gearbox #(.WIDTH(1), .RATIO(2)) dut2 (
    .SCLK(clk), .RST(rst), .D(d[0]), .ALIGNWD(aw), .Q(q2), .VALID(v2), .SLIP(s2)
  );
  iddr_gearbox #(.WIDTH(3), .RATIO(4)) dut4 (
    .SCLK(clk), .RST(rst), .D(d), .ALIGNWD(aw), .Q(q4), .VALID(v4), .SLIP(s4)
  );
  iddr_gearbox #(.WIDTH(1), .RATIO(8)) dut8 (
    .SCLK(clk), .RST(rst), .D(d[0]), .ALIGNWD(aw), .Q(q8), .VALID(v8), .SLIP(s8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One posedge cycle: rise bit sampled at posedge, fall bit at the following negedge
  task automatic cyc(input logic rs, input logic a, input logic [2:0] dr, input logic [2:0] df);
    rst = rs;
    aw  = a;
    d   = dr;
    @(posedge clk);
    #1;
    d = df;
    @(negedge clk);
    #1;
  endtask

  task automatic rst_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 3'b000, 3'b000);
  endtask

  // Drive one RATIO=4 word (bit0 oldest per lane) over two cycles starting on a wrap edge
  task automatic word4(input logic [11:0] drv, input logic [11:0] exp,
                       input logic aw_a, input logic aw_b);
    logic [2:0] ra, fa, rb, fb;
    for (int n = 0; n < 3; n++) begin
      ra[n] = drv[n*4];
      fa[n] = drv[n*4 + 1];
      rb[n] = drv[n*4 + 2];
      fb[n] = drv[n*4 + 3];
    end
    exp4_q.push_back(exp);
    cyc(1'b0, aw_a, ra, fa);
    check("valid4_wrap", 32'(v4), 32'd1);
    cyc(1'b0, aw_b, rb, fb);
    check("valid4_mid", 32'(v4), 32'd0);
  endtask

  // Scoreboard: every VALID on an enabled instance pops and compares one expected word
  always @(negedge clk) begin
    if (en2 && v2) begin
      if (exp2_q.size() == 0) check("q2_extra_valid", 32'(v2), 32'd0);
      else begin
        e2 = exp2_q.pop_front();
        check("q2_word", 32'(q2), 32'(e2));
      end
    end
    if (en4 && v4) begin
      if (exp4_q.size() == 0) check("q4_extra_valid", 32'(v4), 32'd0);
      else begin
        e4 = exp4_q.pop_front();
        check("q4_word", 32'(q4), 32'(e4));
      end
    end
    if (en8 && v8) begin
      if (exp8_q.size() == 0) check("q8_extra_valid", 32'(v8), 32'd0);
      else begin
        e8 = exp8_q.pop_front();
        check("q8_word", 32'(q8), 32'(e8));
      end
    end
  end

  initial begin
    rst = 1'b1;
    aw  = 1'b0;
    d   = 3'b000;

    // Reset state
    rst_cycles(2);
    check("rst_q2", 32'(q2), 32'd0);
    check("rst_v2", 32'(v2), 32'd0);
    check("rst_s2", 32'(s2), 32'd0);
    check("rst_q4", 32'(q4), 32'd0);
    check("rst_v4", 32'(v4), 32'd0);
    check("rst_s4", 32'(s4), 32'd0);
    check("rst_q8", 32'(q8), 32'd0);
    check("rst_v8", 32'(v8), 32'd0);
    check("rst_s8", 32'(s8), 32'd0);

    // RATIO=2: VALID every cycle, first word is the reset pair, then 2'b01
    en2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      exp2_q.push_back((k == 1) ? 2'b00 : 2'b01);
      cyc(1'b0, 1'b0, 3'b001, 3'b000);
      check("valid2_every", 32'(v2), 32'd1);
    end
    en2 = 1'b0;
    check("q2_drain", 32'(exp2_q.size()), 32'd0);

    // RATIO=4, three lanes with distinct words
    rst_cycles(2);
    en4 = 1'b1;
    exp4_q.push_back(12'h000);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    check("valid4_first", 32'(v4), 32'd0);
    word4(12'h86D, 12'h86D, 1'b0, 1'b0);
    word4(12'h5F2, 12'h5F2, 1'b0, 1'b0);
    word4(12'hE09, 12'hE09, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    check("valid4_flush", 32'(v4), 32'd1);
    en4 = 1'b0;
    check("q4_drain_lanes", 32'(exp4_q.size()), 32'd0);

    // RATIO=4 bitslip on repeating 1,0,0,0
    rst_cycles(2);
    en4 = 1'b1;
    exp4_q.push_back(12'h000);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    word4(12'h111, 12'h111, 1'b0, 1'b0);
    check("slip4_0", 32'(s4), 32'd0);
    word4(12'h111, 12'h222, 1'b0, 1'b1);
    check("slip4_1", 32'(s4), 32'd1);
    word4(12'h111, 12'h222, 1'b1, 1'b0);
    check("slip4_lockout", 32'(s4), 32'd1);
    word4(12'h111, 12'h444, 1'b0, 1'b1);
    check("slip4_2", 32'(s4), 32'd2);
    word4(12'h111, 12'h888, 1'b0, 1'b1);
    check("slip4_3", 32'(s4), 32'd3);
    word4(12'h111, 12'h111, 1'b0, 1'b1);
    check("slip4_wrap", 32'(s4), 32'd0);
    word4(12'h111, 12'h111, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    en4 = 1'b0;
    check("q4_drain_slip", 32'(exp4_q.size()), 32'd0);

    // RATIO=8: ALIGNWD held 12 cycles advances SLIP once per 4 cycles
    rst_cycles(2);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b1, 3'b000, 3'b000);
      check("slip8_hold", 32'(s8), 32'(1 + (k - 1) / 4));
    end
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    check("slip8_release", 32'(s8), 32'd3);

    // RATIO=8: slip accepted on a wrap edge, that word keeps the old offset
    rst_cycles(2);
    en8 = 1'b1;
    exp8_q.push_back(8'b1011_0100);
    cyc(1'b0, 1'b0, 3'b001, 3'b000);
    cyc(1'b0, 1'b0, 3'b001, 3'b001);
    cyc(1'b0, 1'b0, 3'b000, 3'b001);
    check("valid8_before_wrap", 32'(v8), 32'd0);
    exp8_q.push_back(8'b1000_1101);
    cyc(1'b0, 1'b1, 3'b000, 3'b001);
    check("valid8_wrap1", 32'(v8), 32'd1);
    check("slip8_coincident", 32'(s8), 32'd1);
    cyc(1'b0, 1'b0, 3'b001, 3'b000);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    cyc(1'b0, 1'b0, 3'b001, 3'b001);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    check("valid8_wrap2", 32'(v8), 32'd1);
    en8 = 1'b0;
    check("q8_drain", 32'(exp8_q.size()), 32'd0);

    // RATIO=4: one-cycle reset mid-word
    rst_cycles(2);
    cyc(1'b0, 1'b0, 3'b111, 3'b111);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    check("q4_pre_reset", 32'(q4), 32'hCCC);
    cyc(1'b0, 1'b1, 3'b000, 3'b000);
    check("slip4_pre_reset", 32'(s4), 32'd1);
    cyc(1'b1, 1'b0, 3'b000, 3'b000);
    check("midrst_q4", 32'(q4), 32'd0);
    check("midrst_v4", 32'(v4), 32'd0);
    check("midrst_s4", 32'(s4), 32'd0);
    en4 = 1'b1;
    exp4_q.push_back(12'hCCC);
    cyc(1'b0, 1'b0, 3'b111, 3'b111);
    check("midrst_valid_p1", 32'(v4), 32'd0);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    check("midrst_valid_p2", 32'(v4), 32'd1);
    en4 = 1'b0;
    check("q4_drain_rst", 32'(exp4_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iddr_gearbox.md
Name: iddr_gearbox

Overview:
- Parametrised input DDR deserialiser: the generalised successor to a 1:2 input DDR register.
- Samples WIDTH data lanes on both edges of SCLK and emits RATIO-bit words per lane with a VALID strobe.
- Adds runtime word alignment (bitslip) via ALIGNWD.
- Sits behind the I/O pads in the simulation-model library and is used as the behavioural model for the x2/x4 gearing primitives.

Parameters:
- WIDTH, 1: number of independent data lanes.
- RATIO, 4: bits per output word per lane. Legal values 2, 4, 8; any other value is a fatal elaboration error.

Ports:
- SCLK  input  1  sole clock. Data sampled on both edges; all other state updates on posedge.
- RST  input  1  synchronous, active-high reset. Sampled on posedge SCLK; also sampled on negedge for the falling-capture register.
- D  input  WIDTH  serial DDR data, one bit per lane.
- ALIGNWD  input  1  bitslip request, sampled on posedge.
- Q  output  WIDTH*RATIO  deserialised words. Lane n occupies Q[n*RATIO +: RATIO]. Bit 0 of each lane slice is the oldest bit.
- VALID  output  1  one-cycle strobe: Q updated this cycle.
- SLIP  output  clog2(RATIO)  current bit offset, for debug and verification.

Behaviour:
- Capture:
  - r[n] <= D[n] on posedge.
  - f[n] <= D[n] on negedge.
  - Either register clears to 0 on an edge of its own kind where RST=1.
- Push: on each posedge with RST=0, each lane shifts the pair (r, then f) into a 2*RATIO-bit history H. H[0] is the newest bit; r is older than f.
  - At the first non-reset posedge the pair pushed is (0,0).
- Word counter cnt, 0..RATIO/2-1:
  - Increments on every non-reset posedge.
  - When cnt==RATIO/2-1 at a posedge, cnt wraps to 0, Q is loaded and VALID=1 for that cycle. Otherwise VALID=0 and Q holds.
  - RATIO=2 gives VALID every cycle.
- Word extraction per lane: Q_lane[i] = H'[RATIO-1-i+SLIP], where H' is the history including the pair pushed at that same edge.
- Latency: the bit sampled on the posedge just before a wrap edge lands in Q_lane[RATIO-2] at that wrap edge when SLIP=0. Its paired falling bit lands in Q_lane[RATIO-1].
- Bitslip:
  - ALIGNWD=1 at a posedge with lockout=0 increments SLIP modulo RATIO and starts a lockout of RATIO/2 posedges.
  - ALIGNWD is ignored while lockout is nonzero.
  - The new SLIP applies from the next VALID.
  - Each increment delays the word boundary by one bit; SLIP=RATIO-1 wraps to 0.
  - Holding ALIGNWD high continuously advances SLIP once per RATIO/2 cycles.
- Simultaneous ALIGNWD and wrap edge: the slip is accepted, and the word loaded at that edge still uses the old SLIP.
- Reset:
  - RST=1 at a posedge clears r, H, cnt, SLIP, lockout and Q, and sets VALID=0.
  - Reset asserted mid-word discards the partial word; no VALID is issued for it.
  - The first VALID occurs at the RATIO/2-th non-reset posedge after RST falls.
- Reset values: Q=0, VALID=0, SLIP=0.
- Lanes are fully independent in data and share cnt, SLIP and VALID.

Test Plan:
- RATIO=2, WIDTH=1, RST released, D=1 on rising, 0 on falling, repeated -> from the 2nd VALID onward Q=2'b01 every cycle, VALID held 1.
- RATIO=4, WIDTH=1, stream bits 1,0,1,1 (rise,fall,rise,fall) aligned to cnt=0 -> next VALID Q=4'b1101; stream 0,1,0,0 -> Q=4'b0010; VALID high once per 2 cycles.
- RATIO=4, repeating pattern 1,0,0,0, single ALIGNWD pulse -> SLIP 0->1; the word after the next VALID shows the pattern rotated by one bit (4'b0001 -> 4'b0010); four pulses spaced 2 cycles apart -> SLIP returns to 0 and the original word.
- RATIO=8, ALIGNWD held high 12 cycles -> SLIP increments exactly 3 times (lockout 4 cycles); ALIGNWD coincident with a wrap edge -> that word uses the old SLIP.
- RATIO=4, WIDTH=3, distinct patterns per lane -> each lane slice matches its own pattern, no cross-lane leakage.
- RST pulsed high for one posedge mid-word -> Q=0, VALID=0, SLIP=0 next cycle; first VALID exactly 2 posedges after release, with Q[1:0]=2'b00 (reset pair).
